imem_ctrl: RTL and testbench

Sequencer for the 128 × 32 instruction SRAM. It owns the memory's address, read/write-enable and write-data lines. It boot-loads the memory through a valid/ready stream and then runs a program counter that fetches one instruction per cycle into a registered output for the pipeline's IF stage. It sits between the boot/loader source, the pipeline control (stall, branch, halt) and the instruction memory.

---
 rtl/imem_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_ctrl: boot-loads a 2^ADX_LENGTH x DATA_WIDTH instruction SRAM   |
// | from a valid/ready stream, then fetches one instruction per cycle.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADX_LENGTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_err,
  input  logic                  run,
  input  logic                  stall,
  input  logic                  br_en,
  input  logic [ADX_LENGTH-1:0] br_target,
  input  logic                  halt_req,
  output logic [ADX_LENGTH-1:0] mem_adx,
  output logic                  mem_WrEn,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADX_LENGTH-1:0] pc,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [ADX_LENGTH-1:0] c_ADX_MAX = '1;
  localparam logic [ADX_LENGTH-1:0] c_ADX_ONE = {{(ADX_LENGTH-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic [ADX_LENGTH-1:0]   r_fetch_pc;
  logic [ADX_LENGTH-1:0]   r_wptr;
  logic [DATA_WIDTH-1:0]   r_instr;
  logic [ADX_LENGTH-1:0]   r_pc;
  logic                    r_instr_valid;
  logic                    r_load_err;

  logic                    w_in_load;
  logic                    w_load_wr;

  assign w_in_load = (r_state == S_LOAD);
  assign w_load_wr = w_in_load && load_valid;

  assign load_ready  = w_in_load;
  assign mem_WrEn    = ~w_load_wr;
  assign mem_adx     = w_in_load ? r_wptr : r_fetch_pc;
  assign mem_wdata   = w_in_load ? load_data : '0;
  assign load_err    = r_load_err;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign state       = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= '0;
      r_wptr        <= '0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_instr_valid <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          r_instr_valid <= 1'b0;
          if (load_start) begin
            r_state    <= S_LOAD;
            r_wptr     <= '0;
            r_load_err <= 1'b0;
          end else if (run) begin
            r_state    <= S_RUN;
            r_fetch_pc <= '0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            r_wptr <= r_wptr + c_ADX_ONE;
            // A full memory without load_last ends the load and flags overflow.
            if (load_last) begin
              r_state <= S_IDLE;
            end else if (r_wptr == c_ADX_MAX) begin
              r_state    <= S_IDLE;
              r_load_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (halt_req) begin
            r_state       <= S_HALT;
            r_instr_valid <= 1'b0;
          end else if (br_en) begin
            // The word fetched this cycle is wrong-path, so drop it.
            r_fetch_pc    <= br_target;
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_instr       <= mem_rdata;
            r_pc          <= r_fetch_pc;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= r_fetch_pc + c_ADX_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_ctrl: randomized self-checking bench with SRAM and fetch model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_last, load_ready, load_err;
  logic [31:0] load_data;
  logic        run, stall, br_en, halt_req;
  logic [6:0]  br_target, mem_adx, pc;
  logic        mem_WrEn, instr_valid;
  logic [31:0] mem_wdata, mem_rdata, instr;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram    [128];
  logic [31:0] ref_mem [128];

  logic [6:0]  e_fpc;
  logic [6:0]  e_pc;
  logic [31:0] e_instr;
  logic        e_valid;

  always #5 clk = ~clk;

  always @(posedge clk) if (!mem_WrEn) sram[mem_adx] <= mem_wdata;
  assign mem_rdata = sram[mem_adx];

  imem_ctrl #(.DATA_WIDTH(32), .ADX_LENGTH(7)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_err(load_err),
    .run(run), .stall(stall), .br_en(br_en), .br_target(br_target),
    .halt_req(halt_req), .mem_adx(mem_adx), .mem_WrEn(mem_WrEn),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .state(state)
  );

  // Fetch behaviour: a branch redirects and bubbles, a stall freezes, else the
  // next sequential word is delivered with its address.
  function automatic void model_step(input bit st, input bit br, input logic [6:0] tgt);
    if (br) begin
      e_fpc   = tgt;
      e_valid = 1'b0;
    end else if (!st) begin
      e_instr = ref_mem[e_fpc];
      e_pc    = e_fpc;
      e_valid = 1'b1;
      e_fpc   = e_fpc + 7'd1;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic stream(input int n, input bit with_last, input bit fixed);
    logic [31:0] w;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if ({state, load_ready, load_err} !== {2'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_enter got %b exp %b", {state, load_ready, load_err}, 4'b0110);
    end
    for (int i = 0; i < n; i++) begin
      w          = fixed ? (32'hA + 32'(i)) : $urandom;
      load_valid = 1'b1;
      load_data  = w;
      load_last  = with_last && (i == n - 1);
      run        = 1'($urandom % 2);
      halt_req   = 1'($urandom % 2);
      #1;
      checks++;
      if ({mem_WrEn, mem_adx, mem_wdata, load_ready} !== {1'b0, 7'(i), w, 1'b1}) begin
        errors++;
        $display("FAIL load_write[%0d] got %h exp %h", i,
                 {mem_WrEn, mem_adx, mem_wdata, load_ready}, {1'b0, 7'(i), w, 1'b1});
      end
      ref_mem[i % 128] = w;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    run        = 1'b0;
    halt_req   = 1'b0;
  endtask

  task automatic run_start();
    run = 1'b1;
    tick();
    run = 1'b0;
    e_fpc   = 7'd0;
    e_valid = 1'b0;
    checks++;
    if ({state, instr_valid} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL run_enter got %b exp %b", {state, instr_valid}, 3'b100);
    end
  endtask

  task automatic halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    e_valid  = 1'b0;
    checks++;
    if ({state, instr_valid, pc, instr} !== {2'd3, 1'b0, e_pc, e_instr}) begin
      errors++;
      $display("FAIL halt got st=%0d v=%b pc=%0d exp st=3 v=0 pc=%0d", state, instr_valid, pc, e_pc);
    end
  endtask

  task automatic fetch_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      model_step(1'b0, 1'b0, 7'd0);
      checks++;
      if ({instr_valid, pc, instr} !== {e_valid, e_pc, e_instr}) begin
        errors++;
        $display("FAIL %s[%0d] got v=%b pc=%0d i=%h exp v=%b pc=%0d i=%h", name, i,
                 instr_valid, pc, instr, e_valid, e_pc, e_instr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({state, instr_valid, pc, instr, mem_WrEn, mem_adx, mem_wdata, load_ready, load_err} !==
        {2'd0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got st=%0d v=%b pc=%0d i=%h we=%b adx=%0d wd=%h rdy=%b err=%b exp idle zeros we=1",
               state, instr_valid, pc, instr, mem_WrEn, mem_adx, mem_wdata, load_ready, load_err);
    end
    rst = 1'b0;
    e_fpc = 7'd0; e_pc = 7'd0; e_instr = 32'd0; e_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    stream(3, 1'b1, 1'b1);
    checks++;
    if ({state, load_ready, load_err, mem_WrEn} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL load_done got %b exp %b", {state, load_ready, load_err, mem_WrEn}, 5'b00001);
    end
    run_start();
    fetch_cycles(3, "basic_fetch");
    halt();
  endtask

  task automatic test_overflow();
    stream(128, 1'b0, 1'b0);
    load_valid = 1'b1;
    load_data  = $urandom;
    #1;
    checks++;
    if ({state, load_err, mem_WrEn, load_ready} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL overflow got st=%0d err=%b we=%b rdy=%b exp st=0 err=1 we=1 rdy=0",
               state, load_err, mem_WrEn, load_ready);
    end
    tick();
    load_valid = 1'b0;
    stream(128, 1'b1, 1'b0);
    checks++;
    if ({state, load_err} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_last got st=%0d err=%b exp st=0 err=0", state, load_err);
    end
  endtask

  task automatic test_wrap();
    run_start();
    fetch_cycles(130, "wrap");
    halt();
  endtask

  task automatic test_branch();
    run_start();
    fetch_cycles(5, "pre_branch");
    br_en = 1'b1; br_target = 7'd40;
    tick();
    br_en = 1'b0;
    model_step(1'b0, 1'b1, 7'd40);
    checks++;
    if ({instr_valid, pc} !== {1'b0, 7'd4}) begin
      errors++;
      $display("FAIL branch_bubble got v=%b pc=%0d exp v=0 pc=4", instr_valid, pc);
    end
    fetch_cycles(2, "post_branch");
    checks++;
    if (pc !== 7'd41) begin
      errors++;
      $display("FAIL branch_seq got pc=%0d exp 41", pc);
    end
    halt();
  endtask

  task automatic test_stall();
    logic [6:0] t;
    run_start();
    fetch_cycles(3, "pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({instr_valid, pc, instr} !== {1'b1, 7'd2, ref_mem[2]}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%0d i=%h exp v=1 pc=2 i=%h",
                 i, instr_valid, pc, instr, ref_mem[2]);
      end
    end
    stall = 1'b0;
    fetch_cycles(1, "stall_release");
    t = 7'($urandom);
    stall = 1'b1; br_en = 1'b1; br_target = t;
    tick();
    br_en = 1'b0; stall = 1'b0;
    model_step(1'b1, 1'b1, t);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_branch got v=%b exp 0", instr_valid);
    end
    fetch_cycles(1, "stall_branch_target");
    checks++;
    if (pc !== t) begin
      errors++;
      $display("FAIL stall_branch_pc got %0d exp %0d", pc, t);
    end
    halt();
  endtask

  task automatic test_random_run();
    bit st, br;
    logic [6:0] t;
    run_start();
    for (int i = 0; i < 300; i++) begin
      st = ($urandom % 4) == 0;
      br = ($urandom % 8) == 0;
      t  = 7'($urandom);
      stall = st; br_en = br; br_target = t;
      load_start = 1'($urandom % 2);
      run = 1'($urandom % 2);
      tick();
      model_step(st, br, t);
      checks++;
      if ({state, instr_valid, pc, instr} !== {2'd2, e_valid, e_pc, e_instr}) begin
        errors++;
        $display("FAIL random[%0d] got st=%0d v=%b pc=%0d i=%h exp st=2 v=%b pc=%0d i=%h", i,
                 state, instr_valid, pc, instr, e_valid, e_pc, e_instr);
      end
    end
    stall = 1'b0; br_en = 1'b0; load_start = 1'b0; run = 1'b0;
    halt();
  endtask

  task automatic test_async_reset();
    run_start();
    fetch_cycles(21, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({state, instr_valid, pc, instr} !== {2'd0, 1'b0, 7'd0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset got st=%0d v=%b pc=%0d i=%h exp all zero", state, instr_valid, pc, instr);
    end
    tick();
    rst = 1'b0;
    e_pc = 7'd0; e_instr = 32'd0; e_valid = 1'b0;
    tick();
    run_start();
    fetch_cycles(5, "post_reset");
    halt();
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0; load_valid = 1'b0; load_data = 32'd0; load_last = 1'b0;
    run = 1'b0; stall = 1'b0; br_en = 1'b0; br_target = 7'd0; halt_req = 1'b0;
    test_reset();
    test_load_basic();
    test_overflow();
    test_wrap();
    test_branch();
    test_stall();
    test_random_run();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
